// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: default widths, reset PC,
// FSM state encoding and a PC alignment helper.
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  // Instructions are word aligned; any set bit in [1:0] is a misaligned target.
  function automatic logic is_misaligned(input logic [1:0] i_lsb);
    return (i_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC arithmetic for a retiring instruction.
// Ports:
//   i_pc, i_is_true, i_jalr_sel, i_imm, i_rs1_data : current PC and branch info
//   o_next_pc                                      : sequential, PC-relative or
//                                                    register-relative target
// All sums wrap modulo 2^XLEN.
module next_pc_calc #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_is_true,
  input  logic            i_jalr_sel,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;

  assign w_seq  = i_pc + XLEN'(4);
  assign w_base = i_jalr_sel ? i_rs1_data : i_pc;
  assign w_sum  = w_base + i_imm;

  // JALR targets have bit 0 forced low before the alignment check.
  always_comb begin
    o_next_pc = w_seq;
    if (i_is_true) begin
      o_next_pc = i_jalr_sel ? (w_sum & ~XLEN'(1)) : w_sum;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: fetches one instruction at a time from instruction memory,
// holds it for decode until retire, then steers the PC to the next target.
// A misaligned target raises a sticky trap and parks the unit until reset.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   is_true/jalr_sel/imm/
//   rs1_data/retire           : retire-time control-flow information
//   imem_req/imem_addr/
//   imem_ack/imem_rdata       : instruction-memory read handshake
//   instr/instr_valid/pc/
//   pc_plus4/trap             : decode-side view of the held instruction
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_true,
  input  logic            jalr_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            retire,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap
);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_trap;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_instr_nxt;
  logic            w_trap_nxt;
  logic            w_imem_req;
  logic            w_instr_valid;
  logic [XLEN-1:0] w_next_pc;

  next_pc_calc #(
    .XLEN (XLEN)
  ) u_next_pc_calc (
    .i_pc       (r_pc),
    .i_is_true  (is_true),
    .i_jalr_sel (jalr_sel),
    .i_imm      (imm),
    .i_rs1_data (rs1_data),
    .o_next_pc  (w_next_pc)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_trap  <= w_trap_nxt;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_trap_nxt    = r_trap;
    w_imem_req    = 1'b0;
    w_instr_valid = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack) begin
          w_instr_nxt = imem_rdata;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_instr_valid = 1'b1;
        if (retire) begin
          if (is_misaligned(w_next_pc[1:0])) begin
            w_trap_nxt  = 1'b1;
            w_state_nxt = ST_TRAP;
          end else begin
            w_pc_nxt    = w_next_pc;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_TRAP: begin
        w_state_nxt = ST_TRAP;
      end
      default: begin
        w_state_nxt = ST_TRAP;
      end
    endcase

    // Reset masks the handshake outputs in the cycle it is asserted.
    if (rst) begin
      w_imem_req    = 1'b0;
      w_instr_valid = 1'b0;
    end
  end

  assign imem_req    = w_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = w_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + XLEN'(4);
  assign trap        = r_trap;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected fetch addresses are queued when
// a reset or retire is driven and popped when the unit issues the fetch.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        is_true;
  logic        jalr_sel;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr_q[$];

  pc_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .is_true     (is_true),
    .jalr_sel    (jalr_sel),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .retire      (retire),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .trap        (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output logic [31:0] v);
    if (exp_addr_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=empty expected=entry");
      v = 'x;
    end else begin
      v = exp_addr_q.pop_front();
    end
  endtask

  // Called in a FETCH cycle: compares the request against the scoreboard,
  // acks with zero wait and checks the instruction is held next cycle.
  task automatic do_fetch(input string tag, input logic [31:0] rdata);
    logic [31:0] e;
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    pop_exp(e);
    check({tag, "_addr"}, imem_addr, e);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr, rdata);
    check({tag, "_req_lo"}, 32'(imem_req), 32'd0);
  endtask

  task automatic do_retire(input logic t, input logic j, input logic [31:0] im,
                           input logic [31:0] rs1, input logic [31:0] exp_next);
    retire   = 1'b1;
    is_true  = t;
    jalr_sel = j;
    imm      = im;
    rs1_data = rs1;
    exp_addr_q.push_back(exp_next);
    step();
    retire   = 1'b0;
    is_true  = 1'($urandom);
    jalr_sel = 1'($urandom);
    imm      = $urandom;
    rs1_data = $urandom;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; is_true = 1'b0; jalr_sel = 1'b0; imm = '0; rs1_data = '0;
    retire = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

    // Reset state
    step();
    step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_trap", 32'(trap), 32'd0);
    exp_addr_q.push_back(32'h0);
    rst = 1'b0;
    #1;

    // First fetch, acked in the first request cycle
    do_fetch("first", 32'h0000_0093);
    check("first_pc", pc, 32'h0);

    // JAL to 0x100, then sequential step
    do_retire(1'b1, 1'b0, 32'h100, 32'h0, 32'h100);
    do_fetch("jal100", 32'h0000_0013);
    check("pc100", pc, 32'h100);
    check("pc100_plus4", pc_plus4, 32'h104);
    do_retire(1'b0, 1'b0, 32'h0, 32'h0, 32'h104);
    do_fetch("seq104", 32'h1111_1111);

    // Back to 0x100, then negative PC-relative offset
    do_retire(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h100);
    do_fetch("back100", 32'h2222_2222);
    do_retire(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'hF8);
    do_fetch("neg8", 32'h3333_3333);

    // JALR with bit 0 cleared
    do_retire(1'b1, 1'b1, 32'h11, 32'h1000, 32'h1010);
    do_fetch("jalr1010", 32'h4444_4444);

    // Wrap-around at the top of the address space
    do_retire(1'b1, 1'b1, 32'hD, 32'hFFFF_FFF0, 32'hFFFF_FFFC);
    do_fetch("top", 32'h5555_5555);
    check("top_plus4", pc_plus4, 32'h0);
    do_retire(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("wrap_trap", 32'(trap), 32'd0);
    do_fetch("wrap", 32'h6666_6666);

    // Jump to 0x40 with ack withheld for 5 cycles; retire noise ignored
    do_retire(1'b1, 1'b0, 32'h40, 32'h0, 32'h40);
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, 32'h40);
      retire  = 1'($urandom);
      is_true = 1'b1;
      imm     = 32'h8;
      step();
    end
    retire = 1'b0;
    do_fetch("stall40", 32'h7777_7777);

    // EXEC hold without retire; ack and branch noise ignored
    for (int i = 0; i < 3; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      is_true    = 1'($urandom);
      imm        = $urandom;
      step();
      check("hold_instr", instr, 32'h7777_7777);
      check("hold_pc", pc, 32'h40);
      check("hold_valid", 32'(instr_valid), 32'd1);
    end
    imem_ack = 1'b0;

    // Misaligned JALR target 0x202 traps
    do_retire(1'b1, 1'b1, 32'h0, 32'h203, 32'h0);
    void'(exp_addr_q.pop_back());
    check("trap_flag", 32'(trap), 32'd1);
    check("trap_pc", pc, 32'h40);
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom);
      retire   = ~imem_ack;
      is_true  = 1'b0;
      step();
      check("trap_req", 32'(imem_req), 32'd0);
      check("trap_valid", 32'(instr_valid), 32'd0);
      check("trap_sticky", 32'(trap), 32'd1);
      check("trap_pc_hold", pc, 32'h40);
    end
    imem_ack = 1'b0;
    retire   = 1'b0;

    // Reset out of trap
    rst = 1'b1;
    step();
    check("rst2_trap", 32'(trap), 32'd0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_instr", instr, 32'h0);
    rst = 1'b0;
    #1;
    check("rst2_req", 32'(imem_req), 32'd1);

    // Reset arrives with ack in the third fetch cycle
    step();
    step();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rst3_req_masked", 32'(imem_req), 32'd0);
    step();
    rst      = 1'b0;
    imem_ack = 1'b0;
    check("rst3_instr", instr, 32'h0);
    check("rst3_pc", pc, 32'h0);
    #1;
    check("rst3_valid", 32'(instr_valid), 32'd0);
    check("rst3_req", 32'(imem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter XLEN, default 32, meaning the address and data width.
REQ-003 SHALL have one clock and one reset. Reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 is_true  in  1  take-branch/jump from the branch decoder, valid while retire=1.
REQ-007 jalr_sel  in  1  target is register-relative (JALR) rather than PC-relative.
REQ-008 imm  in  XLEN  sign-extended immediate.
REQ-009 rs1_data  in  XLEN  register-file operand for JALR.
REQ-010 retire  in  1  pulse: the current instruction completes execution this cycle.
REQ-011 imem_req  out  1  instruction-memory read request.
REQ-012 imem_addr  out  XLEN  instruction-memory address.
REQ-013 imem_ack  in  1  instruction-memory read done; imem_rdata valid this cycle.
REQ-014 imem_rdata  in  XLEN  fetched instruction word.
REQ-015 instr  out  XLEN  latched instruction for decode.
REQ-016 instr_valid  out  1  instr is held and awaiting retire.
REQ-017 pc  out  XLEN  address of instr.
REQ-018 pc_plus4  out  XLEN  pc+4, the link value for JAL/JALR.
REQ-019 trap  out  1  sticky flag: misaligned next-PC detected.

Function
REQ-020 The FSM SHALL have states FETCH, EXEC and TRAP.
REQ-021 FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ack; on imem_ack, instr<=imem_rdata, and the next state is EXEC.
REQ-022 EXEC: instr_valid=1 and imem_req=0. Without retire, the state is held and instr, pc and pc_plus4 stay stable.
REQ-023 EXEC with retire: next_pc is computed as follows.
  - is_true=0: pc+4.
  - is_true=1, jalr_sel=0: pc+imm.
  - is_true=1, jalr_sel=1: (rs1_data+imm) with bit0 cleared.
REQ-024 All additions SHALL be modulo 2^XLEN; wrap-around is legal and not flagged.
REQ-025 If next_pc[1:0]==2'b00: pc<=next_pc and the next state is FETCH.
REQ-026 If next_pc[1:0]!=2'b00: pc is unchanged, trap<=1, and the next state is TRAP.
REQ-027 TRAP: imem_req=0, instr_valid=0, and the state is held until rst; retire and imem_ack are ignored.
REQ-028 imem_ack outside FETCH SHALL be ignored.
REQ-029 is_true, jalr_sel, imm and rs1_data SHALL be ignored when retire=0.
REQ-030 retire outside EXEC SHALL be ignored.
REQ-031 Latency: retire in cycle n gives imem_req=1 with the new address in cycle n+1.
REQ-032 Latency: imem_ack in cycle m gives instr_valid=1 in cycle m+1.
REQ-033 Each instruction takes at least 2 cycles.
REQ-034 imem_ack in the same cycle imem_req first rises SHALL be accepted (zero-wait memory).
REQ-035 pc_plus4 SHALL be combinationally pc+4 (mod 2^XLEN).

Reset
REQ-036 With rst=1 at a rising edge, the block SHALL set pc=RESET_PC, state=FETCH, instr=0 and trap=0.
REQ-037 With rst=1, the block SHALL drive imem_req=0 and instr_valid=0 during that cycle.
REQ-038 rst SHALL dominate all other inputs, including mid-fetch with imem_ack=1 and during retire.
REQ-039 imem_req SHALL rise in the first cycle after rst deasserts.

Structure
REQ-040 Shared package: XLEN, RESET_PC default, state encoding (FETCH=2'd0, EXEC=2'd1, TRAP=2'd2).
REQ-041 The next-PC arithmetic (REQ-023) SHALL be a combinational sub-module next_pc_calc.
REQ-042 The FSM and the instr/pc registers SHALL reside in pc_fetch_unit.

Verification
REQ-043 Reset, then ack in the first cycle with rdata=32'h0000_0093 -> imem_addr=0, then instr=32'h0000_0093 and instr_valid=1 next cycle.
REQ-044 pc=32'h100, retire, is_true=0 -> next imem_addr=32'h104; pc_plus4=32'h104 before retire.
REQ-045 pc=32'h100, retire, is_true=1, jalr_sel=0, imm=-8 -> imem_addr=32'hF8.
REQ-046 retire, is_true=1, jalr_sel=1, rs1_data=32'h203, imm=0 -> imem_addr=32'h202? No: bit0 cleared gives 32'h202, misaligned -> trap=1, state TRAP, pc unchanged, imem_req stays 0 for 10 cycles of ack/retire noise.
REQ-047 pc=32'hFFFF_FFFC, retire, is_true=0 -> imem_addr=32'h0, trap=0.
REQ-048 imem_ack withheld for 5 cycles -> imem_addr stable, imem_req=1 throughout; rst asserted with ack in cycle 3 -> instr stays 0, and pc=RESET_PC after.
